regfile: RTL
============

Name: regfile

Overview:
- 32-entry × 64-bit register file: two combinational read ports and one synchronous write port.
- Built from the 64-bit enabled register block, plus a 5:32 write-enable decoder and two 32:1 64-bit read multiplexers.
- Serves as the register file feeding the datapath's ALU operands in the single-cycle CPU.
- Register 31 (XZR) is hardwired to zero.

Parameters:
- WIDTH, 64, data width of each register and of read/write data.
- ADDR_W, 5, register index width; entry count is 2**ADDR_W = 32.
- ZERO_REG, 31, index that always reads zero and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ReadRegister1  input  ADDR_W  index for read port 1.
- ReadRegister2  input  ADDR_W  index for read port 2.
- WriteRegister  input  ADDR_W  index for write port.
- WriteData  input  WIDTH  data written on the next rising edge when RegWrite=1.
- RegWrite  input  1  write enable.
- ReadData1  output  WIDTH  contents of entry ReadRegister1.
- ReadData2  output  WIDTH  contents of entry ReadRegister2.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset); it is sampled only on the rising edge of clk.
- Reset:
  - On a rising edge with reset=1, all 32 entries become 0; reset overrides RegWrite in the same cycle.
  - After reset, ReadData1 and ReadData2 read 0 for every index.
  - Before the first reset edge, entry contents are undefined, except that ZERO_REG reads 0 at all times.
- Write:
  - On a rising edge with reset=0 and RegWrite=1, entry[WriteRegister] <= WriteData.
  - Exactly one entry is enabled through the decoder; all other entries hold.
  - RegWrite=0: no entry changes.
- Zero register:
  - Writes to index ZERO_REG are discarded; its decoder enable is forced to 0.
  - Any read of index ZERO_REG returns 0 regardless of history.
- Read:
  - Purely combinational, zero-cycle latency from the address to ReadData.
  - Both ports are independent; the same index on both ports returns identical data.
- Read-during-write:
  - There is no bypass. In the write cycle, a read of WriteRegister returns the old value.
  - The new value appears immediately after the rising edge.
- Write data is the full WIDTH bits, with no sign extension or masking.
- Every entry holds its value indefinitely while unaddressed by a write.
- Reset asserted mid-sequence clears everything on that edge, including a write presented in the same cycle. The write is lost and is not retried.
- Structure: 31 writable instances of the enabled register block plus a constant-zero entry for index 31. The decoder drives each instance's enable from RegWrite & (WriteRegister==i).

Test Plan:
- Reset: hold reset=1 for 1 edge with RegWrite=1, WriteRegister=3, WriteData=64'hFFFF → all 32 indices read 0 on both ports afterwards.
- Write/read all:
  - Write i*64'h0000010204080001 to each i=0..30, one per cycle.
  - Read back pairs (i, 30-i) → each port returns its exact pattern.
  - Index 31 still reads 0.
- Zero register: write 64'hDEADBEEFCAFEF00D to index 31 with RegWrite=1 → ReadData1/2 at index 31 stay 0, and no other entry changes.
- Enable gating: with entry 5 = 64'h1234, set RegWrite=0 and WriteData=64'hABCD to index 5 for 3 cycles → entry 5 still reads 64'h1234.
- Read-during-write:
  - Entry 7 = 64'h1111; write 64'h2222 to entry 7 while reading index 7 on both ports.
  - Before the edge, both ports show 64'h1111; after the edge, both show 64'h2222.
- Reset mid-operation: fill entries 0..30 with nonzero data, then assert reset for one edge → all read 0. A write of 64'h55 to index 2 on the next edge reads back 64'h55, and the others stay 0.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32-entry x 64-bit register file for the single-cycle CPU datapath.
//   Two combinational read ports and one synchronous write port. Entry ZERO_REG
//   (XZR) is a constant zero: it is never enabled for writes and always reads 0.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous active-high reset, clears every entry
//   ReadRegister1 index for read port 1
//   ReadRegister2 index for read port 2
//   WriteRegister index for the write port
//   WriteData     data written on the next rising edge when RegWrite=1
//   RegWrite      write enable
//   ReadData1     contents of entry ReadRegister1 (combinational)
//   ReadData2     contents of entry ReadRegister2 (combinational)
module regfile #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Every element is driven by exactly one continuous assign below.
    logic [WIDTH-1:0] entry [Depth];

    for (genvar i = 0; i < Depth; i++) begin : g_entry
        if (i == ZERO_REG) begin : g_zero
            assign entry[i] = '0;
        end else begin : g_reg
            logic             wr_en;
            logic [WIDTH-1:0] data_q;

            // One-hot write decode for this entry.
            assign wr_en = RegWrite && (WriteRegister == ADDR_W'(i));

            // Enabled register; reset takes priority over a same-cycle write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                end else if (wr_en) begin
                    data_q <= WriteData;
                end
            end

            assign entry[i] = data_q;
        end
    end

    // No write bypass: a read of the register being written returns the old value.
    always_comb begin
        ReadData1 = entry[ReadRegister1];
        ReadData2 = entry[ReadRegister2];
    end

endmodule
